// File: rtl/bram_pkg.sv
// Shared types and width helpers for the byte-enable block RAM.
package bram_pkg;

  typedef enum logic {CLEAR, READY} bram_state_t;

  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_LANE_WIDTH = 8;

  function automatic int unsigned word_width(
    input int unsigned lanes,
    input int unsigned lane_width
  );
    return lanes * lane_width;
  endfunction

endpackage

// File: rtl/bram_lane.sv
// One write-enable lane: LANE_WIDTH x DEPTH block array
// with a registered read port and write-first forwarding.
module bram_lane #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LANE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  zero,
  input  logic                  fwd,
  output logic [LANE_WIDTH-1:0] q
);

  (* ram_style = "block" *)
  logic [LANE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // q only moves on a read, so it holds between reads
  always_ff @(posedge clock) begin
    if (clr) begin
      q <= '0;
    end else if (re) begin
      unique case (1'b1)
        zero:    q <= '0;
        fwd:     q <= wdata;
        default: q <= mem[raddr];
      endcase
    end
  end

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port byte-enable RAM with post-reset clear sweep.
// Define BRAM_OUT_REG_EN for an extra output register (latency 2).
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       w_en,
  input  logic [LANES-1:0]                           w_be,
  input  logic [ADDR_WIDTH-1:0]                      write_addr,
  input  logic [word_width(LANES, LANE_WIDTH)-1:0]   write_data,
  input  logic                                       r_en,
  input  logic [ADDR_WIDTH-1:0]                      read_addr,
  output logic [word_width(LANES, LANE_WIDTH)-1:0]   read_data,
  output logic                                       read_valid,
  output logic                                       init_done
);

  localparam int unsigned WIDTH = word_width(LANES, LANE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  bram_state_t           state_q;
  bram_state_t           state_d;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_d;
  logic                  sweep;
  logic                  ready;
  logic                  w_ok;
  logic                  r_ok;
  logic                  wr;
  logic                  rd;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      q;
  logic                  valid_q;

  if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
    assign w_ok = 1'b1;
    assign r_ok = 1'b1;
  end else begin : g_range
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);
    assign w_ok = write_addr < LIMIT;
    assign r_ok = read_addr < LIMIT;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= CLEAR;
      clr_addr <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_addr <= clr_addr_d;
      valid_q  <= rd;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr;
    sweep      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        sweep      = reset_n;
        clr_addr_d = clr_addr + 1'b1;
        if (clr_addr == LAST) begin
          state_d = READY;
        end
      end
      READY: state_d = READY;
    endcase
  end

  assign ready = state_q == READY;
  assign wr    = ready & w_en & w_ok;
  assign rd    = ready & r_en;
  assign hit   = wr & r_en & r_ok
               & (write_addr == read_addr);
  assign waddr = sweep ? clr_addr : write_addr;
  assign wdata = sweep ? '0 : write_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bram_lane #(
      .DEPTH      (DEPTH),
      .LANE_WIDTH (LANE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clock (clock),
      .clr   (!reset_n),
      .we    (sweep | (wr & w_be[i])),
      .waddr (waddr),
      .wdata (wdata[i*LANE_WIDTH +: LANE_WIDTH]),
      .re    (rd),
      .raddr (read_addr),
      .zero  (!r_ok),
      .fwd   (hit & w_be[i]),
      .q     (q[i*LANE_WIDTH +: LANE_WIDTH])
    );
  end

`ifdef BRAM_OUT_REG_EN
  logic [WIDTH-1:0] data2_q;
  logic             valid2_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data2_q  <= '0;
      valid2_q <= 1'b0;
    end else begin
      valid2_q <= valid_q;
      if (valid_q) begin
        data2_q <= q;
      end
    end
  end

  assign read_data  = data2_q;
  assign read_valid = valid2_q;
`else
  assign read_data  = q;
  assign read_valid = valid_q;
`endif

  assign init_done = ready;

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench for bram_sdp_be: sweep, byte enables,
// collision forwarding, read latency and mid-stream reset.
module tb_bram_sdp_be;

`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_en;
  logic [3:0]  w_be;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        r_en;
  logic [4:0]  read_addr;
  logic [31:0] read_data;
  logic        read_valid;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;

  bram_sdp_be dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .w_en       (w_en),
    .w_be       (w_be),
    .write_addr (write_addr),
    .write_data (write_data),
    .r_en       (r_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    w_en = 1'b1; write_addr = a; write_data = d; w_be = be;
    tick();
    w_en = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    r_en = 1'b1; read_addr = a;
    tick();
    r_en = 1'b0;
    repeat (LAT - 1) tick();
    chk({tag, "_valid"}, 32'(read_valid), 32'd1);
    chk({tag, "_data"}, read_data, exp);
  endtask

  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk({tag, "_init"}, 32'(init_done), 32'(i == 32));
      chk({tag, "_valid"}, 32'(read_valid), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; w_en = 1'b0; w_be = '0;
    write_addr = '0; write_data = '0;
    r_en = 1'b0; read_addr = '0;

    // reset held for two edges
    repeat (2) tick();
    chk("rst_valid", 32'(read_valid), 32'd0);
    chk("rst_data", read_data, 32'd0);
    chk("rst_init", 32'(init_done), 32'd0);

    // requests during the sweep must be dropped
    reset_n = 1'b1;
    r_en = 1'b1; read_addr = 5'd3;
    w_en = 1'b1; write_addr = 5'd3;
    write_data = 32'hDEADBEEF; w_be = 4'hF;
    sweep_check("sweep1");
    r_en = 1'b0; w_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd("clr_read", 5'(a), 32'd0);
    end

    // partial-lane update
    wr(5'd5, 32'hAABBCCDD, 4'b1111);
    wr(5'd5, 32'h11223344, 4'b0101);
    rd("be_merge", 5'd5, 32'hAA22CC44);

    // collision forwarding, lane 3 only
    wr(5'd7, 32'h01020304, 4'hF);
    w_en = 1'b1; r_en = 1'b1;
    write_addr = 5'd7; read_addr = 5'd7;
    write_data = 32'hFF000000; w_be = 4'b1000;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("coll_valid", 32'(read_valid), 32'd1);
    chk("coll_data", read_data, 32'hFF020304);
    rd("coll_after", 5'd7, 32'hFF020304);

    // collision with empty mask is a no-op write
    w_en = 1'b1; r_en = 1'b1;
    write_data = 32'hFFFFFFFF; w_be = 4'b0000;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    repeat (LAT - 1) tick();
    chk("nobe_data", read_data, 32'hFF020304);
    rd("nobe_after", 5'd7, 32'hFF020304);

    // exact read latency and hold
    wr(5'd9, 32'h12345678, 4'hF);
    repeat (2) tick();
    chk("idle_valid", 32'(read_valid), 32'd0);
    r_en = 1'b1; read_addr = 5'd9;
    tick();
    r_en = 1'b0;
    chk("lat_e0_valid", 32'(read_valid), 32'(LAT == 1));
    chk("lat_e0_data", read_data,
        (LAT == 1) ? 32'h12345678 : 32'hFF020304);
    tick();
    chk("lat_e1_valid", 32'(read_valid), 32'(LAT == 2));
    chk("lat_e1_data", read_data, 32'h12345678);
    tick();
    chk("hold_valid", 32'(read_valid), 32'd0);
    chk("hold_data", read_data, 32'h12345678);

    // reset in the middle of a read stream
    r_en = 1'b1;
    read_addr = 5'd5; tick();
    read_addr = 5'd7; tick();
    read_addr = 5'd9; tick();
    reset_n = 1'b0;
    tick();
    chk("mid_valid", 32'(read_valid), 32'd0);
    chk("mid_init", 32'(init_done), 32'd0);
    chk("mid_data", read_data, 32'd0);
    reset_n = 1'b1;
    sweep_check("sweep2");
    r_en = 1'b0;
    rd("gone5", 5'd5, 32'd0);
    rd("gone7", 5'd7, 32'd0);
    rd("gone9", 5'd9, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
